// File: rtl/fpu_sort16.sv
// fpu_sort16: frame-based ascending sorter for fp16 bit patterns.
//
// A frame of 1..N elements is loaded over the input stream, sorted in place
// by an N-phase odd-even transposition network, then streamed out in order.
// Input and output never overlap: the sorter is in exactly one of LOAD,
// SORT or DRAIN.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holds data/last stable while valid & ~ready. Ready never
// depends combinationally on valid.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_data    fp16 input element
//   in_valid   in_data valid
//   in_last    final element of frame (qualified by in_valid)
//   in_ready   sorter accepts an element (LOAD only)
//   out_data   sorted element
//   out_valid  out_data valid (DRAIN only)
//   out_last   final sorted element
//   out_ready  downstream accepts out_data
//   busy       high in SORT or DRAIN
//   dbg_state  current FSM state (0 LOAD, 1 SORT, 2 DRAIN)
module fpu_sort16 #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Map a pattern onto an unsigned key with the same total order as the
    // fp16 comparator: negatives are inverted (larger magnitude -> smaller key,
    // -NaN lowest), positives get the sign bit set (above every negative).
    function automatic logic [15:0] ord_key(input logic [15:0] v);
        return v[15] ? ~v : (v ^ 16'h8000);
    endfunction

    function automatic logic gt(input logic [15:0] a, input logic [15:0] b);
        return ord_key(a) > ord_key(b);
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  phase_q, phase_d;
    logic [15:0]    buf_q [N];
    logic [15:0]    buf_d [N];
    // Keeps in_ready low until the first edge after reset release.
    logic           rdy_en_q;
    logic           frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            count_q  <= '0;
            idx_q    <= '0;
            phase_q  <= '0;
            rdy_en_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= 16'h0000;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            rdy_en_q <= 1'b1;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        buf_d     = buf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 16'h0000;
        frame_end = 1'b0;

        case (state_q)
            ST_LOAD: begin
                in_ready = rdy_en_q;
                if (in_valid && rdy_en_q) begin
                    // The Nth element closes the frame whatever in_last says.
                    frame_end = in_last || (count_q == CW'(N - 1));
                    for (int i = 0; i < N; i++) begin
                        if (CW'(i) == count_q) begin
                            buf_d[i] = in_data;
                        end else if (frame_end && (CW'(i) > count_q)) begin
                            // Max pattern: padding always sinks to the tail
                            // and is never drained.
                            buf_d[i] = 16'h7FFF;
                        end
                    end
                    count_d = count_q + CW'(1);
                    if (frame_end) begin
                        state_d = ST_SORT;
                        phase_d = '0;
                    end
                end
            end

            ST_SORT: begin
                // Even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..
                // Pairs within a phase are disjoint. Equal elements stay put.
                for (int i = 0; i < N - 1; i++) begin
                    if ((i % 2) == int'(phase_q[0])) begin
                        if (gt(buf_q[i], buf_q[i+1])) begin
                            buf_d[i]   = buf_q[i+1];
                            buf_d[i+1] = buf_q[i];
                        end
                    end
                end
                phase_d = phase_q + CW'(1);
                if (phase_q == CW'(N - 1)) begin
                    state_d = ST_DRAIN;
                    phase_d = '0;
                    idx_d   = '0;
                end
            end

            ST_DRAIN: begin
                out_valid = 1'b1;
                out_data  = buf_q[idx_q[IW-1:0]];
                out_last  = (idx_q == (count_q - CW'(1)));
                if (out_ready) begin
                    idx_d = idx_q + CW'(1);
                    if (out_last) begin
                        state_d = ST_LOAD;
                        count_d = '0;
                        idx_d   = '0;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign busy      = (state_q == ST_SORT) || (state_q == ST_DRAIN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fpu_sort16.sv
// Testbench for fpu_sort16 (N = 8): table of frames with expected sorted
// output, random frames checked against an independent fp16 ordering model,
// backpressure, and resets in the middle of SORT and DRAIN.
module tb_fpu_sort16;

    localparam int N = 8;

    typedef logic [N-1:0][15:0] frame_t;

    typedef struct {
        int     len;
        frame_t din;
        frame_t dexp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // {last, data} of each element still expected on the output.
    logic [16:0] exp_q[$];

    fpu_sort16 #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- reference ordering model ----------------
    function automatic bit fp_gt(input logic [15:0] a, input logic [15:0] b);
        if (a == b) return 1'b0;
        if (a[15] != b[15]) return b[15];           // positive > negative
        if (!a[15]) return a[14:0] > b[14:0];       // both positive
        return a[14:0] < b[14:0];                   // both negative
    endfunction

    function automatic frame_t model_sort(input int len, input frame_t d);
        frame_t r = d;
        logic [15:0] tmp;
        for (int i = 1; i < len; i++) begin
            for (int j = i; j > 0; j--) begin
                if (fp_gt(r[j-1], r[j])) begin
                    tmp = r[j-1]; r[j-1] = r[j]; r[j] = tmp;
                end
            end
        end
        return r;
    endfunction

    function automatic frame_t pk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
        frame_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    // ---------------- scoreboard / output monitor ----------------
    logic        stall_p = 1'b0;
    logic [15:0] stall_d = 16'h0000;
    logic        stall_l = 1'b0;

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p && out_valid) begin
                check("hold_data", 32'(out_data), 32'(stall_d));
                check("hold_last", 32'(out_last), 32'(stall_l));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e[15:0]));
                    check("out_last", 32'(out_last), 32'(e[16]));
                end
            end
            stall_p = out_valid && !out_ready;
            stall_d = out_data;
            stall_l = out_last;
        end
    end

    // ---------------- driver tasks ----------------
    // Pushes the expected output, then feeds the frame. Returns the number of
    // the cycle in which the last element was accepted.
    task automatic drive_frame(input int len, input frame_t din, input frame_t dexp,
                               output int t_acc);
        int n;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back({(k == len - 1), dexp[k]});
        end
        t_acc = 0;
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            in_data  = din[k];
            in_valid = 1'b1;
            // A full frame ends on the Nth element; leave in_last low there.
            in_last  = (k == len - 1) && (len < N);
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) timeout("in_ready_wait");
            t_acc = cyc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input int len, input frame_t din, input frame_t dexp, input bit bp);
        int t_acc;
        int n;
        drive_frame(len, din, dexp, t_acc);
        out_ready = !bp;
        @(negedge clk);
        check("in_ready_after_last", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("first_out_valid");
        else check("latency", 32'(cyc - t_acc), 32'(N + 1));
        n = 0;
        while (n < 500) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
            if (bp) out_ready = ~out_ready;
            @(negedge clk);
            if (bp) check("in_ready_stalled", 32'(in_ready), 32'd0);
            n++;
        end
        if (n >= 500) timeout("drain");
        out_ready = 1'b1;
        @(negedge clk);
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    task automatic reset_now(input string tag);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_q.delete();
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check({tag, "_in_ready_release"}, 32'(in_ready), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t   vecs[5];
        frame_t din;
        int     t_acc;
        int     len;
        int     n;

        vecs[0].len  = 8;
        vecs[0].din  = pk(16'h4000, 16'hBC00, 16'h3C00, 16'h0000, 16'h8000, 16'hC000, 16'h7C00, 16'h3800);
        vecs[0].dexp = pk(16'hC000, 16'hBC00, 16'h8000, 16'h0000, 16'h3800, 16'h3C00, 16'h4000, 16'h7C00);
        vecs[1].len  = 3;
        vecs[1].din  = pk(16'h3C00, 16'hBC00, 16'h4000, 0, 0, 0, 0, 0);
        vecs[1].dexp = pk(16'hBC00, 16'h3C00, 16'h4000, 0, 0, 0, 0, 0);
        vecs[2].len  = 8;
        vecs[2].din  = pk(16'h8000, 16'h0000, 16'h8000, 16'h3C00, 16'h3C00, 16'h0000, 16'hBC00, 16'hBC00);
        vecs[2].dexp = pk(16'hBC00, 16'hBC00, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h3C00, 16'h3C00);
        vecs[3].len  = 1;
        vecs[3].din  = pk(16'h5555, 0, 0, 0, 0, 0, 0, 0);
        vecs[3].dexp = pk(16'h5555, 0, 0, 0, 0, 0, 0, 0);
        vecs[4].len  = 4;
        vecs[4].din  = pk(16'h7E00, 16'hFE00, 16'h7C00, 16'hFC00, 0, 0, 0, 0);
        vecs[4].dexp = pk(16'hFE00, 16'hFC00, 16'h7C00, 16'h7E00, 0, 0, 0, 0);

        #2;
        reset_now("rst_init");

        // Table frames; the first one drains under toggling backpressure.
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].len, vecs[i].din, vecs[i].dexp, (i == 0));
        end

        // Random frames against the ordering model.
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, N);
            din = '0;
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 3))
                    0: din[k] = 16'($urandom_range(0, 65535));
                    1: din[k] = {1'($urandom_range(0, 1)), 15'h0000};
                    2: din[k] = {1'($urandom_range(0, 1)), 5'h1F, 10'($urandom_range(0, 3) << 8)};
                    default: din[k] = 16'h7FFF;
                endcase
            end
            run_frame(len, din, model_sort(len, din), r[0]);
        end

        // Reset during SORT phase 3.
        out_ready = 1'b1;
        drive_frame(vecs[0].len, vecs[0].din, vecs[0].dexp, t_acc);
        repeat (4) @(negedge clk);
        check("sort_state", 32'(dbg_state), 32'd1);
        check("sort_busy", 32'(busy), 32'd1);
        #2;
        reset_now("rst_sort");

        // Reset during DRAIN index 2.
        drive_frame(vecs[2].len, vecs[2].din, vecs[2].dexp, t_acc);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("drain_reset_wait");
        repeat (2) @(negedge clk);
        check("drain_valid", 32'(out_valid), 32'd1);
        #2;
        reset_now("rst_drain");

        // Fresh two-element frame after the resets.
        run_frame(2, pk(16'h4000, 16'h3C00, 0, 0, 0, 0, 0, 0),
                  pk(16'h3C00, 16'h4000, 0, 0, 0, 0, 0, 0), 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
